// File: rtl/piso.sv
`default_nettype none
// ============================================================================
//  Module   : piso
//  Purpose  : Parallel-in, serial-out shift register with a busy/last bit counter.
//             Define PISO_LSB_FIRST_EN to shift LSB first. The default is MSB first.
//  Revision : 1.0  initial release
// ============================================================================
module piso #(
  parameter int   WIDTH = 4,
  parameter logic FILL  = 1'b0
) (
  input  logic [WIDTH-1:0] d,
  input  logic             res,
  input  logic             clk,
  input  logic             load,
  output logic             y,
  output logic             busy,
  output logic             last
);

  localparam int             CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  c_WIDTH = CW'(WIDTH);
  localparam logic [CW-1:0]  c_ONE   = CW'(1);
  localparam logic [CW-1:0]  c_ZERO  = '0;

  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_sr_shift;
  logic             w_out_bit;

`ifdef PISO_LSB_FIRST_EN
  assign w_sr_shift = {FILL, r_sr[WIDTH-1:1]};
  assign w_out_bit  = r_sr[0];
`else
  assign w_sr_shift = {r_sr[WIDTH-2:0], FILL};
  assign w_out_bit  = r_sr[WIDTH-1];
`endif

  // Load has priority over shifting. A reload while busy drops the remaining bits.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_sr  <= '0;
      r_cnt <= c_ZERO;
    end else if (load) begin
      r_sr  <= d;
      r_cnt <= c_WIDTH;
    end else begin
      r_sr  <= w_sr_shift;
      if (r_cnt != c_ZERO) r_cnt <= r_cnt - c_ONE;
    end
  end

  assign y    = w_out_bit;
  assign busy = (r_cnt != c_ZERO);
  assign last = (r_cnt == c_ONE);

endmodule
`default_nettype wire

// File: tb/tb_piso.sv
`default_nettype none
// ============================================================================
//  Module   : tb_piso
//  Purpose  : Randomized self-checking bench for piso against a bit-queue model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_piso;

  localparam int   WIDTH = 4;
  localparam logic FILL  = 1'b1;  // non-zero fill makes the fill path observable

  logic [WIDTH-1:0] d;
  logic             res;
  logic             clk;
  logic             load;
  logic             y;
  logic             busy;
  logic             last;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: bits still to appear on y, in output order, plus unshifted-bit count.
  logic q[$];
  int   rem;

  piso #(.WIDTH(WIDTH), .FILL(FILL)) u_dut (
    .d    (d),
    .res  (res),
    .clk  (clk),
    .load (load),
    .y    (y),
    .busy (busy),
    .last (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    q.delete();
    for (int i = 0; i < WIDTH; i++) q.push_back(1'b0);
    rem = 0;
  endfunction

  function automatic void m_load(input logic [WIDTH-1:0] v);
    q.delete();
`ifdef PISO_LSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++) q.push_back(v[i]);
`else
    for (int i = WIDTH - 1; i >= 0; i--) q.push_back(v[i]);
`endif
    rem = WIDTH;
  endfunction

  function automatic void m_shift();
    if (q.size() > 0) void'(q.pop_front());
    if (rem > 0) rem--;
  endfunction

  task automatic check_outputs(input string tag);
    logic ey;
    ey = (q.size() > 0) ? q[0] : FILL;
    chk({tag, ".y"},    32'(y),    32'(ey));
    chk({tag, ".busy"}, 32'(busy), 32'(rem != 0));
    chk({tag, ".last"}, 32'(last), 32'(rem == 1));
  endtask

  // One clock edge with the given inputs, then check just after the edge.
  task automatic step(input logic ld, input logic [WIDTH-1:0] dd, input string tag);
    load = ld;
    d    = dd;
    @(posedge clk);
    if (ld) m_load(dd);
    else    m_shift();
    #1;
    check_outputs(tag);
  endtask

  task automatic async_reset_pulse(input string tag);
    #3 res = 1'b0;
    m_reset();
    #1 check_outputs({tag, ".async"});
    load = 1'b1;
    d    = '1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 check_outputs({tag, ".held"});
    end
    #2 res  = 1'b1;
    load = 1'b0;
  endtask

  initial begin
    res  = 1'b0;
    load = 1'b1;
    d    = 4'b1111;
    m_reset();
    #1 check_outputs("rst0");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 check_outputs("rst_hold");
    end
    #2 res  = 1'b1;
    load = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b0, 4'b1111, "post_rst");

    // Single word
    step(1'b1, 4'b1001, "single_ld");
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0110, "single_sh");

    // Reload mid-word
    step(1'b1, 4'b1001, "reload_a");
    step(1'b0, 4'b0000, "reload_sh");
    step(1'b1, 4'b1010, "reload_b");
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0000, "reload_sh2");

    // Back-to-back, gapless
    step(1'b1, 4'b1100, "b2b_a");
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0000, "b2b_sh");
    step(1'b1, 4'b0011, "b2b_b");
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0000, "b2b_sh2");

    // Load held high for several edges
    for (int i = 0; i < 3; i++) step(1'b1, 4'b1010, "load_held");
    step(1'b0, 4'b0000, "load_held_sh");

    // Async reset mid-word
    step(1'b1, 4'b1111, "arst_ld");
    step(1'b0, 4'b0000, "arst_sh");
    async_reset_pulse("arst");
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0000, "arst_after");

    // LSB-first patterns (direction follows build configuration)
    step(1'b1, 4'b1000, "dir_ld");
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0000, "dir_sh");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) async_reset_pulse("rnd");
      step(($urandom_range(0, 99) < 25), WIDTH'($urandom), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
`default_nettype wire
